// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical-memory port between the instruction-fetch side (I)
//   and the data side (D). One transaction at a time, round-robin on ties.
//
// Ports
//   clk, rst                   : clock, asynchronous active-high reset
//   i_read / i_address         : I-side read request (held until i_resp)
//   i_rdata / i_resp           : I-side read data and one-cycle completion
//   d_read / d_write           : D-side request (write wins if both high)
//   d_address / d_wdata        : D-side line address and write data
//   d_rdata / d_resp           : D-side read data and one-cycle completion
//   pmem_read / pmem_write     : memory strobes, held until pmem_resp
//   pmem_address / pmem_wdata  : latched address / write data
//   pmem_rdata / pmem_resp     : memory return data and completion pulse
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q;
  logic                last_d_q;       // 1: D was granted last, 0: I was
  logic                pmem_read_q;
  logic                pmem_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;

  logic                i_req;
  logic                d_req;
  logic                grant_i_d;
  logic                grant_d_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the side that did not win last time is granted. last_d_q
  // resets to 1 so the first tie after reset goes to I.
  always_comb begin
    grant_i_d = i_req & (~d_req | last_d_q);
    grant_d_d = d_req & (~i_req | ~last_d_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b1;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i_d) begin
            state_q      <= BUSY_I;
            last_d_q     <= 1'b0;
            addr_q       <= i_address;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b1;
            pmem_write_q <= 1'b0;
          end else if (grant_d_d) begin
            state_q      <= BUSY_D;
            last_d_q     <= 1'b1;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            // An illegal read+write request is treated as a write.
            pmem_read_q  <= ~d_write;
            pmem_write_q <= d_write;
          end
        end
        BUSY_I, BUSY_D: begin
          // Requester inputs are not looked at here; only the memory
          // completion moves the FSM, and the return cycle is never used
          // for re-arbitration.
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is a same-cycle pass-through of pmem_resp so the pipeline
  // can release its stall without an extra cycle; idle rdata reads as 0.
  assign i_resp  = (state_q == BUSY_I) & pmem_resp;
  assign d_resp  = (state_q == BUSY_D) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                side_d;
    logic [ADDR_W-1:0] addr;
    bit                wr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_count = 0;
  bit   mem_auto = 1'b0;

  localparam logic [LINE_W-1:0] A5_LINE = {32{8'hA5}};
  localparam logic [LINE_W-1:0] W1_LINE = {16{16'h1234}};
  localparam logic [LINE_W-1:0] W7_LINE = {32{8'h77}};
  localparam logic [LINE_W-1:0] W4_LINE = {32{8'h44}};

  function automatic void check(string nm, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory model: line contents are a fixed pattern per address.
  function automatic logic [LINE_W-1:0] mem_data(logic [ADDR_W-1:0] a);
    if (a == 32'h0000_1000) return A5_LINE;
    return {8{a}};
  endfunction

  // Auto-responding memory: pmem_resp in the 3rd cycle after the strobe.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        if (pmem_resp) begin
          pmem_resp  = 1'b0;
          pmem_rdata = '0;
          cnt        = 0;
        end else if (pmem_read || pmem_write) begin
          cnt++;
          if (cnt == 3) begin
            pmem_resp  = 1'b1;
            pmem_rdata = mem_data(pmem_address);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares the memory port and responses against the head of
  // the scoreboard.
  initial begin
    bit   prev_resp;
    exp_t e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!i_resp) check("i_rdata_zero_without_resp", i_rdata, '0);
        if (!d_resp) check("d_rdata_zero_without_resp", d_rdata, '0);
        check("strobes_exclusive", pmem_read & pmem_write, 0);
        if (prev_resp) begin
          check("idle_gap_read", pmem_read, 0);
          check("idle_gap_write", pmem_write, 0);
        end
        if (pmem_read || pmem_write) begin
          check("strobe_has_txn", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb[0];
            check("pmem_address", pmem_address, e.addr);
            check("pmem_write_op", pmem_write, e.wr);
            check("pmem_read_op", pmem_read, !e.wr);
            if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
            if (pmem_resp) check("resp_on_pmem_resp", i_resp | d_resp, 1);
          end
        end
        if (i_resp || d_resp) begin
          check("resp_has_txn", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("resp_side_d", d_resp, e.side_d);
            check("resp_side_i", i_resp, !e.side_d);
            if (e.side_d) check("d_rdata", d_rdata, e.rdata);
            else          check("i_rdata", i_rdata, e.rdata);
            $display("txn side=%s addr=%h wr=%0d resp at %0t",
                     e.side_d ? "D" : "I", e.addr, e.wr, $time);
          end
          resp_count++;
        end
        prev_resp = i_resp | d_resp;
      end else begin
        prev_resp = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single transaction with no competing requester: checks grant latency,
  // waits for the response and deasserts on the edge after it.
  task automatic do_txn(input bit side_d, input bit rd, input bit wr,
                        input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                        input logic [LINE_W-1:0] exp_rdata, input bit mid_change);
    exp_t e;
    bit   got;
    e.side_d = side_d; e.addr = addr; e.wr = wr; e.wdata = wdata; e.rdata = exp_rdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (side_d) begin
      d_read = rd; d_write = wr; d_address = addr; d_wdata = wdata;
    end else begin
      i_read = 1'b1; i_address = addr;
    end
    @(negedge clk);
    check("strobe_before_grant", pmem_read | pmem_write, 0);
    @(negedge clk);
    check("strobe_cycle_k1", wr ? pmem_write : pmem_read, 1);
    if (mid_change) d_address = 32'h0000_3000;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (side_d ? d_resp : i_resp) got = 1'b1;
      else @(negedge clk);
    end
    check("resp_seen", got, 1);
    @(posedge clk);
    #1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   target;

    // Reset state
    #2;
    check("reset_pmem_read", pmem_read, 0);
    check("reset_pmem_write", pmem_write, 0);
    check("reset_pmem_address", pmem_address, '0);
    check("reset_i_resp", i_resp, 0);
    check("reset_d_resp", d_resp, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mem_auto = 1'b1;

    // I read at 0x1000
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, A5_LINE, 1'b0);
    // D write at 0x2000, address changed mid-transaction
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_2000, W1_LINE, {8{32'h0000_2000}}, 1'b1);
    // Illegal read+write at 0x4000 behaves as a write
    do_txn(1'b1, 1'b1, 1'b1, 32'h0000_4000, W4_LINE, {8{32'h0000_4000}}, 1'b0);
    // D read at 0x2000
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, '0, {8{32'h0000_2000}}, 1'b0);

    // Spurious pmem_resp while idle
    mem_auto = 1'b0;
    @(posedge clk);
    #1 pmem_resp = 1'b1; pmem_rdata = {32{8'h5A}};
    @(negedge clk);
    check("spurious_i_resp", i_resp, 0);
    check("spurious_d_resp", d_resp, 0);
    check("spurious_pmem_read", pmem_read, 0);
    check("spurious_pmem_write", pmem_write, 0);
    @(posedge clk);
    #1 pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk);
    check("after_spurious_strobes", pmem_read | pmem_write, 0);

    // Round-robin with both sides held: I, D, I, D
    do_reset();
    mem_auto = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e.side_d = 1'b0; e.addr = 32'h0000_5000; e.wr = 1'b0; e.wdata = '0;
      e.rdata = {8{32'h0000_5000}};
      sb.push_back(e);
      e.side_d = 1'b1; e.addr = 32'h0000_7000; e.wr = 1'b1; e.wdata = W7_LINE;
      e.rdata = {8{32'h0000_7000}};
      sb.push_back(e);
    end
    target = resp_count + 4;
    @(posedge clk);
    #1;
    i_read = 1'b1; i_address = 32'h0000_5000;
    d_write = 1'b1; d_address = 32'h0000_7000; d_wdata = W7_LINE;
    for (int n = 0; n < 200 && resp_count < target; n++) @(posedge clk);
    #1;
    i_read = 1'b0; d_write = 1'b0;
    check("rr_resp_count", resp_count, target);
    check("rr_queue_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    check("rr_idle_after", pmem_read | pmem_write, 0);

    // Reset while BUSY_D with pmem_write high
    mem_auto = 1'b0;
    e.side_d = 1'b1; e.addr = 32'h0000_6000; e.wr = 1'b1; e.wdata = W7_LINE;
    e.rdata = '0;
    sb.push_back(e);
    @(posedge clk);
    #1 d_write = 1'b1; d_address = 32'h0000_6000; d_wdata = W7_LINE;
    repeat (2) @(negedge clk);
    check("abort_pre_write", pmem_write, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_write_dropped", pmem_write, 0);
    check("abort_read_low", pmem_read, 0);
    d_write = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 pmem_resp = 1'b1; pmem_rdata = {32{8'hEE}};
    @(negedge clk);
    check("abort_no_d_resp", d_resp, 0);
    check("abort_no_i_resp", i_resp, 0);
    check("abort_idle_write", pmem_write, 0);
    @(posedge clk);
    #1 pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
